// File: rtl/lsu_align.sv
// Load/store alignment unit: byte/half/word requests -> word-addressed accesses with strobes.
// Define LSU_MISALIGNED_SPLIT_EN to split word-crossing accesses; otherwise misaligned ones error.
module lsu_align #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;

  state_e              r_state, w_state_d;
  logic                r_live;
  logic [ADDR_W-1:0]   r_waddr;
  logic [1:0]          r_off;
  logic [1:0]          r_size;
  logic                r_we;
  logic                r_uns;
  logic [31:0]         r_wdata;
  logic                r_err;

  logic                w_req_err;
  logic                w_split;
  logic [3:0]          w_base;
  logic [7:0]          w_mask8;
  logic [63:0]         w_wsh;
  logic [63:0]         w_ld64;
  logic [31:0]         w_ld;
  logic [31:0]         w_ext;
  logic                w_unused_addr;

  assign w_unused_addr = ^req_addr[31:ADDR_W+2];

  always_comb begin
    w_req_err = (req_size == 2'b11);
`ifdef LSU_MISALIGNED_SPLIT_EN
`else
    if (req_size == 2'b01 && req_addr[0])          w_req_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) w_req_err = 1'b1;
`endif
  end

  always_comb begin
    case (r_size)
      2'b00:   w_base = 4'b0001;
      2'b01:   w_base = 4'b0011;
      default: w_base = 4'b1111;
    endcase
  end

  assign w_mask8 = {4'b0000, w_base} << r_off;
  assign w_wsh   = {32'h0, r_wdata} << {r_off, 3'b000};

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic [31:0] r_lo;
  logic [2:0]  w_bytes;

  assign w_bytes = (r_size == 2'b00) ? 3'd1 : (r_size == 2'b01) ? 3'd2 : 3'd4;
  assign w_split = ({1'b0, r_off} + w_bytes) > 3'd4;
  assign w_ld64  = w_split ? {mem_rdata, r_lo} : {32'h0, mem_rdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo <= 32'h0;
    end else if (r_state == StAcc1) begin
      r_lo <= mem_rdata;
    end
  end
`else
  logic w_unused_hi;

  assign w_split     = 1'b0;
  assign w_ld64      = {32'h0, mem_rdata};
  assign w_unused_hi = ^{w_mask8[7:4], w_wsh[63:32]};
`endif

  assign w_ld = 32'(w_ld64 >> {r_off, 3'b000});

  always_comb begin
    case (r_size)
      2'b00:   w_ext = {{24{w_ld[7] & ~r_uns}}, w_ld[7:0]};
      2'b01:   w_ext = {{16{w_ld[15] & ~r_uns}}, w_ld[15:0]};
      default: w_ext = w_ld;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'h0;
    rsp_err   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wstrb = 4'b0000;
    mem_wdata = 32'h0;
    case (r_state)
      StIdle: begin
        req_ready = r_live;
        if (req_valid && r_live) w_state_d = w_req_err ? StResp : StAcc0;
      end
      StAcc0: begin
        mem_addr = r_waddr;
        if (r_we) begin
          mem_write = 1'b1;
          mem_wstrb = w_mask8[3:0];
          mem_wdata = w_wsh[31:0];
        end else begin
          mem_read = 1'b1;
        end
        w_state_d = w_split ? StAcc1 : StResp;
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      StAcc1: begin
        mem_addr = r_waddr + ADDR_W'(1);
        if (r_we) begin
          mem_write = 1'b1;
          mem_wstrb = w_mask8[7:4];
          mem_wdata = w_wsh[63:32];
        end else begin
          mem_read = 1'b1;
        end
        w_state_d = StResp;
      end
`endif
      StResp: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        if (!r_we && !r_err) rsp_rdata = w_ext;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // r_live holds req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_live  <= 1'b0;
      r_waddr <= '0;
      r_off   <= 2'b00;
      r_size  <= 2'b00;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_wdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_live  <= 1'b1;
      r_state <= w_state_d;
      if (r_state == StIdle && req_valid && r_live) begin
        r_waddr <= req_addr[ADDR_W+1:2];
        r_off   <= req_addr[1:0];
        r_size  <= req_size;
        r_we    <= req_we;
        r_uns   <= req_unsigned;
        r_wdata <= req_wdata;
        r_err   <= w_req_err;
      end
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Scoreboard bench for lsu_align with a synchronous word memory model.
module tb_lsu_align;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic [31:0]   req_addr = 32'h0, req_wdata = 32'h0;
  logic          rsp_valid, rsp_err, mem_read, mem_write;
  logic [31:0]   rsp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wstrb;

  lsu_align #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0]   mem [1024];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [31:0]   pl_data = 32'h0;

  always @(posedge clk) begin
    if (mem_read) mem_rdata <= mem[mem_addr];
    if (mem_write)
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (pl_en) mem[pl_addr] <= pl_data;
  end

  typedef struct packed {logic [31:0] rdata; logic err;} exp_t;
  exp_t q[$];

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response strobe is matched against the scoreboard head.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (q.size() == 0) begin
        check("unexpected_rsp", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
      end
    end
  end

  int            acc_n;
  logic [AW-1:0] acc_addr [4];
  logic          acc_wr [4];
  logic [3:0]    acc_strb [4];
  logic [31:0]   acc_wdata [4];
  int            lat;

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    logic both;
    e.rdata = exp_rd;
    e.err   = exp_err;
    q.push_back(e);
    acc_n = 0; lat = 0; both = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 8 && !req_ready; i++) @(negedge clk);
    if (!req_ready) check("req_ready_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (mem_read && mem_write) both = 1'b1;
      if ((mem_read || mem_write) && acc_n < 4) begin
        acc_addr[acc_n] = mem_addr; acc_wr[acc_n] = mem_write;
        acc_strb[acc_n] = mem_wstrb; acc_wdata[acc_n] = mem_wdata;
        acc_n++;
      end
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) check("rsp_timeout", 32'h0, 32'h1);
    check("rd_wr_exclusive", {31'h0, both}, 32'h0);
  endtask

  task automatic chk_acc(input int i, input logic [AW-1:0] a, input logic wr,
                         input logic [3:0] s, input logic [31:0] d);
    check("acc_addr", 32'(acc_addr[i]), 32'(a));
    check("acc_wr", {31'h0, acc_wr[i]}, {31'h0, wr});
    if (wr) begin
      check("acc_wstrb", {28'h0, acc_strb[i]}, {28'h0, s});
      check("acc_wdata", acc_wdata[i], d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("reset_ready", {31'h0, req_ready}, 32'h0);
    check("reset_outputs", {29'h0, rsp_valid, mem_read, mem_write}, 32'h0);
    preload(AW'(1), 32'hDEADBEEF);
    preload(AW'(2), 32'hCAFEBABE);
    preload(AW'(3), 32'h01234567);
    preload(AW'(1023), 32'h01020304);
    preload(AW'(0), 32'h05060708);
    @(negedge clk) rst_n = 1'b1;
    #1 check("ready_before_edge", {31'h0, req_ready}, 32'h0);
    @(posedge clk);
    #1 check("ready_after_release", {31'h0, req_ready}, 32'h1);

    do_req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'hDEADBEEF, 1'b0);
    check("lw_latency", lat, 2);
    check("lw_acc_count", acc_n, 1);
    chk_acc(0, AW'(1), 1'b0, 4'b0000, 32'h0);
    do_req(1'b0, 2'b00, 1'b0, 32'h07, 32'h0, 32'hFFFFFFDE, 1'b0);
    do_req(1'b0, 2'b00, 1'b1, 32'h07, 32'h0, 32'h000000DE, 1'b0);
    do_req(1'b0, 2'b01, 1'b0, 32'h06, 32'h0, 32'hFFFFDEAD, 1'b0);
    do_req(1'b0, 2'b01, 1'b1, 32'h04, 32'h0, 32'h0000BEEF, 1'b0);
    do_req(1'b1, 2'b01, 1'b0, 32'h0A, 32'h00001234, 32'h0, 1'b0);
    check("sh_acc_count", acc_n, 1);
    chk_acc(0, AW'(2), 1'b1, 4'b1100, 32'h12340000);
    do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'h1234BABE, 1'b0);
    do_req(1'b0, 2'b11, 1'b0, 32'h04, 32'h0, 32'h0, 1'b1);
    check("size11_no_access", acc_n, 0);

`ifdef LSU_MISALIGNED_SPLIT_EN
    do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'hBABEDEAD, 1'b0);
    check("split_lw_latency", lat, 3);
    check("split_lw_acc_count", acc_n, 2);
    chk_acc(0, AW'(1), 1'b0, 4'b0000, 32'h0);
    chk_acc(1, AW'(2), 1'b0, 4'b0000, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, 32'h07, 32'h11223344, 32'h0, 1'b0);
    check("split_sw_acc_count", acc_n, 2);
    chk_acc(0, AW'(1), 1'b1, 4'b1000, 32'h44000000);
    chk_acc(1, AW'(2), 1'b1, 4'b0111, 32'h00112233);
    check("split_sw_word1", mem[1], 32'h44ADBEEF);
    check("split_sw_word2", mem[2], 32'h12112233);
    do_req(1'b0, 2'b01, 1'b0, 32'h05, 32'h0, 32'hFFFFADBE, 1'b0);
    check("half_off1_single", acc_n, 1);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFD, 32'h0, 32'h08010203, 1'b0);
    check("wrap_acc_count", acc_n, 2);
    chk_acc(0, AW'(1023), 1'b0, 4'b0000, 32'h0);
    chk_acc(1, AW'(0), 1'b0, 4'b0000, 32'h0);

    // Split store interrupted by reset in its second access.
    preload(AW'(1), 32'hDEADBEEF);
    preload(AW'(2), 32'hCAFEBABE);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h07;
    req_wdata = 32'h11223344;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 check("acc1_write_active", {31'h0, mem_write}, 32'h1);
`else
    do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1);
    check("misaligned_lw_no_access", acc_n, 0);
    do_req(1'b0, 2'b01, 1'b0, 32'h05, 32'h0, 32'h0, 1'b1);
    check("misaligned_lh_no_access", acc_n, 0);
    do_req(1'b1, 2'b10, 1'b0, 32'h07, 32'h11223344, 32'h0, 1'b1);
    check("misaligned_sw_no_access", acc_n, 0);
    check("misaligned_sw_mem", mem[1], 32'hDEADBEEF);

    // Aligned store interrupted by reset in its only access.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h0C;
    req_wdata = 32'hA5A5A5A5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1 check("acc0_write_active", {31'h0, mem_write}, 32'h1);
`endif
    rst_n = 1'b0;
    #1 check("reset_drops_write", {31'h0, mem_write}, 32'h0);
    check("reset_drops_ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
`ifdef LSU_MISALIGNED_SPLIT_EN
    check("reset_word1", mem[1], 32'h44ADBEEF);
    check("reset_word2", mem[2], 32'hCAFEBABE);
`else
    check("reset_word3", mem[3], 32'h01234567);
`endif
    @(posedge clk);
    #1 check("ready_after_reset", {31'h0, req_ready}, 32'h1);
    do_req(1'b0, 2'b10, 1'b1, 32'h04, 32'h0, mem[1], 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
